// File: rtl/parallax_layers.sv
// Procedural parallax background: LFSR star layers plus random-walk mountain
// silhouettes in a square area, with colour and syncs re-timed by one cycle.
module parallax_layers #(
  parameter int                          AREA_LOG2    = 8,
  parameter int                          STAR_LAYERS  = 3,
  parameter int                          MOUNT_LAYERS = 2,
  parameter int                          RGB_W        = 3,
  parameter int                          STAR_DENSITY = 9,
  parameter logic [MOUNT_LAYERS*10-1:0]  MOUNT_BASE   = {10'd180, 10'd200},
  parameter logic [7:0]                  MOUNT_SEED   = 8'h60
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [9:0]                          hpos,
  input  logic [9:0]                          vpos,
  input  logic                                display_on,
  input  logic                                hsync_in,
  input  logic                                vsync_in,
  input  logic                                pause,
  input  logic [STAR_LAYERS+MOUNT_LAYERS-1:0] layer_en,
  output logic [RGB_W-1:0]                    rgb,
  output logic                                hsync,
  output logic                                vsync,
  output logic [4:0]                          frame
);

  localparam int SUM_W   = RGB_W + 3;
  localparam int RGB_MAX = (1 << RGB_W) - 1;

  function automatic logic [15:0] lfsr16_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] lfsr8_step(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [15:0] star_seed(input int k);
    case (k)
      0:       return 16'hACE1;
      1:       return 16'h6237;
      2:       return 16'h3137;
      default: return 16'h1F1F;
    endcase
  endfunction

  logic [15:0]      star_q     [STAR_LAYERS];
  logic [15:0]      star_d     [STAR_LAYERS];
  logic [9:0]       mh_seed_q  [MOUNT_LAYERS];
  logic [9:0]       mh_seed_d  [MOUNT_LAYERS];
  logic [7:0]       ml_seed_q  [MOUNT_LAYERS];
  logic [7:0]       ml_seed_d  [MOUNT_LAYERS];
  logic [9:0]       mh_work_q  [MOUNT_LAYERS];
  logic [9:0]       mh_work_d  [MOUNT_LAYERS];
  logic [7:0]       ml_work_q  [MOUNT_LAYERS];
  logic [7:0]       ml_work_d  [MOUNT_LAYERS];
  logic [9:0]       h_cur      [MOUNT_LAYERS];
  logic [7:0]       l_cur      [MOUNT_LAYERS];
  logic [4:0]       frame_q, frame_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, vsync_q;
  logic [SUM_W-1:0] sum;

  logic in_area, line_start, frame_start;
  assign in_area     = (hpos[9:AREA_LOG2] == '0) && (vpos[9:AREA_LOG2] == '0);
  assign line_start  = (hpos == 10'd0);
  assign frame_start = line_start && (vpos == 10'd0);
  assign frame_d     = frame_start ? frame_q + 5'd1 : frame_q;

  // NOTE: every signal written here gets its default before any condition,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum = '0;
    for (int k = 0; k < STAR_LAYERS; k++) begin
      star_d[k] = star_q[k];
      if (in_area && (hpos & 10'((1 << k) - 1)) == 10'd0)
        star_d[k] = lfsr16_step(star_q[k]);
      if (in_area && layer_en[k] &&
          star_q[k][15 -: STAR_DENSITY] == {STAR_DENSITY{1'b1}})
        sum = sum + SUM_W'(star_q[k][2:0]);
    end

    for (int m = 0; m < MOUNT_LAYERS; m++) begin
      // Column 0 walks from the seed pair, later columns from the working pair.
      h_cur[m]     = line_start ? mh_seed_q[m] : mh_work_q[m];
      l_cur[m]     = line_start ? ml_seed_q[m] : ml_work_q[m];
      mh_work_d[m] = mh_work_q[m];
      ml_work_d[m] = ml_work_q[m];
      mh_seed_d[m] = mh_seed_q[m];
      ml_seed_d[m] = ml_seed_q[m];

      if (in_area) begin
        mh_work_d[m] = l_cur[m][0] ? h_cur[m] + 10'd1 : h_cur[m] - 10'd1;
        ml_work_d[m] = lfsr8_step(l_cur[m]);
      end else if (line_start) begin
        mh_work_d[m] = mh_seed_q[m];
        ml_work_d[m] = ml_seed_q[m];
      end

      // Layer m scrolls once every 2^m frames.
      if (frame_start && !pause && (frame_q & 5'((1 << m) - 1)) == 5'd0) begin
        mh_seed_d[m] = ml_seed_q[m][0] ? mh_seed_q[m] + 10'd1 : mh_seed_q[m] - 10'd1;
        ml_seed_d[m] = lfsr8_step(ml_seed_q[m]);
      end

      if (in_area && layer_en[STAR_LAYERS+m] && h_cur[m] < vpos)
        sum = sum + SUM_W'(2 << m);
    end
  end

  assign rgb_d = !display_on                 ? '0 :
                 (sum > SUM_W'(RGB_MAX))     ? '1 : sum[RGB_W-1:0];

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      frame_q <= '0;
      for (int k = 0; k < STAR_LAYERS; k++) star_q[k] <= star_seed(k);
      for (int m = 0; m < MOUNT_LAYERS; m++) begin
        mh_seed_q[m] <= MOUNT_BASE[m*10 +: 10];
        mh_work_q[m] <= MOUNT_BASE[m*10 +: 10];
        ml_seed_q[m] <= MOUNT_SEED;
        ml_work_q[m] <= MOUNT_SEED;
      end
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_in;
      vsync_q <= vsync_in;
      frame_q <= frame_d;
      for (int k = 0; k < STAR_LAYERS; k++) star_q[k] <= star_d[k];
      for (int m = 0; m < MOUNT_LAYERS; m++) begin
        mh_seed_q[m] <= mh_seed_d[m];
        mh_work_q[m] <= mh_work_d[m];
        ml_seed_q[m] <= ml_seed_d[m];
        ml_work_q[m] <= ml_work_d[m];
      end
    end
  end

  assign rgb   = rgb_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_parallax_layers.sv
// Bench for parallax_layers: pixel-level reference model checked every cycle,
// plus hand-computed probes of mountain heights, frame wrap and reset behaviour.
module tb_parallax_layers;

  localparam int S = 3;
  localparam int M = 2;
  localparam int D = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in, pause;
  logic [4:0] layer_en;
  logic [2:0] rgb;
  logic       hsync, vsync;
  logic [4:0] frame;

  parallax_layers dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pause(pause), .layer_en(layer_en), .rgb(rgb), .hsync(hsync),
    .vsync(vsync), .frame(frame)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_sat = 0;

  // Reference model state, plain integers.
  int m_star [4];
  int m_hs [M], m_ls [M], m_hw [M], m_lw [M];
  int m_frame;
  int m_star_steps [4];

  // Expected outputs for the most recent clock edge.
  bit exp_valid = 0;
  int exp_rgb, exp_hs, exp_vs, exp_frame;

  function automatic int g16(input int x);
    return (x >> 1) ^ (((x & 1) != 0) ? 'hB400 : 0);
  endfunction

  function automatic int g8(input int x);
    return (x >> 1) ^ (((x & 1) != 0) ? 'hB8 : 0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_star[0] = 'hACE1; m_star[1] = 'h6237; m_star[2] = 'h3137; m_star[3] = 'h1F1F;
    m_hs[0] = 200; m_hs[1] = 180;
    for (int m = 0; m < M; m++) begin
      m_hw[m] = m_hs[m];
      m_ls[m] = 'h60;
      m_lw[m] = 'h60;
    end
    for (int k = 0; k < 4; k++) m_star_steps[k] = 0;
    m_frame = 0;
  endtask

  // Colour expected for pixel (h,v) presented this cycle; advances the model.
  function automatic int model_pixel(input int h, input int v, input bit de);
    bit in_area = (h < 256) && (v < 256);
    bit fs      = (h == 0) && (v == 0);
    int sum     = 0;
    int hc, lc;
    for (int k = 0; k < S; k++) begin
      if (in_area && layer_en[k] && ((m_star[k] >> (16 - D)) == ((1 << D) - 1)))
        sum += m_star[k] & 7;
      if (in_area && (h % (1 << k)) == 0) begin
        m_star[k] = g16(m_star[k]);
        m_star_steps[k]++;
      end
    end
    for (int m = 0; m < M; m++) begin
      hc = (h == 0) ? m_hs[m] : m_hw[m];
      lc = (h == 0) ? m_ls[m] : m_lw[m];
      if (in_area && layer_en[S+m] && hc < v) sum += 2 << m;
      if (in_area) begin
        m_hw[m] = (((lc & 1) != 0) ? hc + 1 : hc + 1023) % 1024;
        m_lw[m] = g8(lc);
      end else if (h == 0) begin
        m_hw[m] = m_hs[m];
        m_lw[m] = m_ls[m];
      end
      if (fs && !pause && (m_frame % (1 << m)) == 0) begin
        m_hs[m] = (((m_ls[m] & 1) != 0) ? m_hs[m] + 1 : m_hs[m] + 1023) % 1024;
        m_ls[m] = g8(m_ls[m]);
      end
    end
    if (fs) m_frame = (m_frame + 1) % 32;
    if (!de) return 0;
    if (sum >= 7) begin
      n_sat++;
      return 7;
    end
    return sum;
  endfunction

  task automatic tick(input int h, input int v, input bit de);
    int e;
    hpos = 10'(h);
    vpos = 10'(v);
    display_on = de;
    e = model_pixel(h, v, de);
    @(posedge clk);
    exp_rgb   = e;
    exp_hs    = hsync_in;
    exp_vs    = vsync_in;
    exp_frame = m_frame;
    exp_valid = 1;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    model_reset();
    #1;
    check("rst_rgb", rgb, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_frame", frame, 0);
    repeat (n) begin
      @(posedge clk);
      exp_rgb = 0; exp_hs = 0; exp_vs = 0; exp_frame = 0;
      exp_valid = 1;
      @(negedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic do_row(input int v, input bit de);
    for (int h = 0; h < 264; h++) begin
      hsync_in = (h >= 256);
      vsync_in = (v >= 256);
      tick(h, v, de);
    end
  endtask

  task automatic sweep(input int rows, input bit de);
    for (int r = 0; r < rows; r++) do_row(r * 8, de);
  endtask

  task automatic probe(input string name, input int v, input int want);
    tick(0, v, 1'b1);
    check(name, rgb, want);
  endtask

  // Single compare process: every cycle with a known expectation.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_vec++;
      if (rgb !== 3'(exp_rgb) || hsync !== 1'(exp_hs) || vsync !== 1'(exp_vs) ||
          frame !== 5'(exp_frame)) begin
        n_err++;
        $display("FAIL pixel h=%0d v=%0d: rgb=%0d hs=%0d vs=%0d frame=%0d, expected rgb=%0d hs=%0d vs=%0d frame=%0d",
                 hpos, vpos, rgb, hsync, vsync, frame, exp_rgb, exp_hs, exp_vs, exp_frame);
      end
    end
  end

  initial begin
    int c2;
    reset = 1'b1; hpos = '0; vpos = '0; display_on = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; pause = 1'b0; layer_en = '0;
    #2;

    // Model pins against hand-computed LFSR steps.
    check("pin_g16", g16('hACE1), 'hE270);
    check("pin_g8", g8('h61), 'h88);

    // Reset with syncs held at hsync_in=1, vsync_in=0.
    do_reset(4);
    tick(5, 5, 1'b1);
    check("post_rst_hsync", hsync, 1);
    check("post_rst_vsync", vsync, 0);

    // Mountain 0 only: seed 200 -> 199 at the first frame start.
    layer_en = 5'b01000;
    tick(0, 0, 1'b1);
    probe("m0_first_v200", 200, 2);
    probe("m0_first_v199", 199, 0);

    // Four unpaused frames: m0 200->196, m1 180->178.
    do_reset(2);
    repeat (4) tick(0, 0, 1'b1);
    check("frame_after4", frame, 4);
    layer_en = 5'b01000;
    probe("m0_h196_v197", 197, 2);
    probe("m0_h196_v196", 196, 0);
    layer_en = 5'b10000;
    probe("m1_h178_v179", 179, 4);
    probe("m1_h178_v178", 178, 0);

    // Paused: heights frozen, frame keeps counting and wraps.
    pause = 1'b1;
    repeat (4) tick(0, 0, 1'b1);
    check("frame_paused8", frame, 8);
    repeat (23) tick(0, 0, 1'b1);
    check("frame_31", frame, 31);
    tick(0, 0, 1'b1);
    check("frame_wrap0", frame, 0);
    probe("m1_paused_v179", 179, 4);
    probe("m1_paused_v178", 178, 0);
    layer_en = 5'b01000;
    probe("m0_paused_v197", 197, 2);
    probe("m0_paused_v196", 196, 0);
    pause = 1'b0;

    // Stars only; layer 2 advances once per four in-area pixels.
    layer_en = 5'b00111;
    c2 = m_star_steps[2];
    do_row(0, 1'b1);
    check("star2_model_steps", m_star_steps[2] - c2, 64);
    check("star2_lfsr", int'(dut.star_q[2]), m_star[2]);
    for (int r = 1; r < 33; r++) do_row(r * 8, 1'b1);

    // Everything masked, then everything enabled with display off.
    layer_en = '0;
    sweep(33, 1'b1);
    layer_en = '1;
    sweep(8, 1'b0);

    // All layers, full sweeps including saturation.
    sweep(33, 1'b1);
    sweep(33, 1'b1);

    // Reset in the middle of a frame, then a fresh frame.
    sweep(16, 1'b1);
    do_reset(3);
    sweep(33, 1'b1);

    $display("saturated pixels seen: %0d", n_sat);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parallax_layers.md
Name: parallax_layers

Overview:
- Parametrised procedural scrolling background for the VGA demo path.
- Produces N star layers and M random-walk "mountain" silhouettes inside a square active area.
- Each mountain layer scrolls at its own per-frame rate; the scroll can be paused, and layers can be masked at runtime.
- Consumes pixel coordinates from the shared sync generator, which is instantiated outside this block.
- Registers RGB and re-times hsync/vsync so all outputs share a fixed 1-cycle latency.

Parameters:
- AREA_LOG2, 8: active area is 2^AREA_LOG2 x 2^AREA_LOG2 pixels at the origin; allowed 6..9.
- STAR_LAYERS, 3: number of star layers, 1..4.
- MOUNT_LAYERS, 2: number of mountain layers, 1..RGB_W-1.
- RGB_W, 3: colour output width.
- STAR_DENSITY, 9: number of top LFSR bits that must all be 1 to light a star, 4..15.
- MOUNT_BASE, {10'd180,10'd200}: packed initial heights; layer m uses slice m.
- MOUNT_SEED, 8'h60: reset value of every mountain LFSR.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hpos  in  10  current pixel x
- vpos  in  10  current pixel y
- display_on  in  1  active video
- hsync_in  in  1  sync from generator
- vsync_in  in  1  sync from generator
- pause  in  1  freeze mountain scrolling
- layer_en  in  STAR_LAYERS+MOUNT_LAYERS  enable mask; stars occupy the low bits
- rgb  out  RGB_W  registered colour
- hsync  out  1  hsync_in delayed 1 cycle
- vsync  out  1  vsync_in delayed 1 cycle
- frame  out  5  frame counter

Behaviour:
- Reset (reset=0, asynchronous):
  - rgb=0, hsync=0, vsync=0, frame=0.
  - Star LFSR k loads its seed: layer 0..3 = 16'hACE1, 16'h6237, 16'h3137, 16'h1F1F.
  - Mountain seed and working LFSRs load MOUNT_SEED.
  - Mountain seed and working heights load MOUNT_BASE[m].
- in_area = hpos < 2^AREA_LOG2 and vpos < 2^AREA_LOG2.
- frame_start = (hpos==0 && vpos==0). On frame_start, frame increments modulo 32.
- Stars, layer k:
  - 16-bit Galois LFSR, right-shift, taps 16'hB400 (XOR applied when bit0=1).
  - Steps on cycles where in_area=1 and hpos[k-1:0]==0; layer 0 steps on every in-area pixel.
  - The LFSR is never reloaded after reset, so the pattern drifts frame to frame.
  - Lit when in_area, its layer_en bit is 1, and the top STAR_DENSITY bits are all 1.
  - Contribution = lfsr[2:0] zero-extended; 0 when not lit.
- Mountains, layer m. Each layer has a seed pair and a working pair of registers (LFSR plus height).
  - Seed pair, on frame_start with pause=0 and (frame mod 2^m)==0:
    - height_seed is incremented if lfsr_seed[0]=1, otherwise decremented (the old bit0 is used).
    - lfsr_seed then steps: 8-bit Galois, taps 8'hB8.
    - With pause=1 the seed pair holds its value.
  - Selected height h_cur = height_seed when hpos==0, else height_work. The pixel at hpos==0 uses the pre-update seed value.
  - Working pair:
    - If in_area, the working pair is updated from the currently selected pair (the seed pair when hpos==0): height_work = h_cur ±1 according to its bit0, and the LFSR steps.
    - Otherwise, if hpos==0, the working pair loads the seed pair unchanged.
  - Heights are 10-bit and wrap modulo 1024. Wrap is legal and is not clamped.
  - Lit when in_area, its layer_en bit is 1, and h_cur < vpos. Contribution = 2<<m.
- Output:
  - Sum all contributions in RGB_W+3 bits, then saturate to 2^RGB_W-1. The sum never wraps.
  - rgb is registered on the next clk edge; rgb=0 when display_on=0.
  - hsync/vsync are registered on the same edge, giving the same 1-cycle latency as rgb.
- Simultaneous events: frame_start coincides with hpos==0. In that cycle the seed update and the working load both read the old seed; the new seed takes effect from line 1.
- Reset mid-frame:
  - Returns all state to reset values at once.
  - Output resumes with the next sampled pixel.
  - The first frame_start after reset still advances the seeds.

Test Plan:
- Reset then hold (hsync_in=1, vsync_in=0) -> hsync/vsync are 0 during reset and 1/0 one cycle after release; rgb=0 throughout reset.
- Mask mountain0 only, defaults, first frame after reset: the seed moves 200->199 at (0,0) because bit0 of 8'h60 is 0. Drive (hpos=0,vpos=200) -> rgb=2 next cycle; drive (hpos=0,vpos=199) -> rgb=0.
- layer_en=0 for a full frame -> rgb=0 at every pixel. Separately, all layers enabled with display_on=0 -> rgb=0.
- Scroll-rate check with default MOUNT_LAYERS=2, over 4 frames:
  - pause=0: mountain0 height_seed changes 4 times and mountain1 changes 2 times.
  - pause=1: both height_seeds are constant; frame still increments and wraps 31->0.
- Stars only, STAR_LAYERS=3: scoreboard compares against a bit-accurate model of the LFSRs. Check that hpos >= 256 or vpos >= 256 gives rgb=0 and that layer 2 steps once per 4 in-area pixels.
- All layers enabled, full frames against the model: every pixel where the model sum is >= 7 gives rgb=7, and no pixel ever shows a wrapped value.
